// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave for the MEM stage.
// Stalls the pipeline while an access is in flight, then pulses ack.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) + 1 : 1;
    localparam logic [29:0]   DEPTH    = 30'(DEPTH_WORDS);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    logic          lat_we;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          addr_ok;
    logic          fast;
    logic          fin_wait;
    logic          access;
    logic          acc_we;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;

    assign accept   = (state == S_IDLE) && req_i;
    assign addr_ok  = (addr_i[1:0] == 2'b00) && (addr_i[31:2] < DEPTH);
    assign fast     = accept && addr_ok && (LATENCY == 1);
    assign fin_wait = (state == S_WAIT) && (cnt == CNT_ONE);
    // Gate with reset so an aborted access never touches the array.
    assign access   = rst_i && (fast || fin_wait);

    assign acc_we    = fast ? we_i : lat_we;
    assign acc_idx   = fast ? addr_i[AW+1:2] : lat_idx;
    assign acc_wdata = fast ? wdata_i : lat_wdata;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; rejected requests skip the wait phase
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (req_i) begin
                    state_nx = (addr_ok && (LATENCY > 1)) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_ONE) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Combinational freeze: accepting cycle plus all wait cycles
    always_comb begin
        stall_o = 1'b0;
        if (rst_i) begin
            stall_o = accept || (state == S_WAIT);
        end
    end

    // Registered completion outputs, latency counter and request latch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else begin
            ack_o <= (state_nx == S_DONE);
            err_o <= accept && !addr_ok;
            if (accept && !addr_ok) begin
                rdata_o <= '0;
            end else if (access && !acc_we) begin
                rdata_o <= mem[acc_idx];
            end
            if (state == S_WAIT) begin
                cnt <= cnt - CNT_ONE;
            end
            if (accept && addr_ok) begin
                cnt       <= CNT_INIT;
                lat_we    <= we_i;
                lat_idx   <= addr_i[AW+1:2];
                lat_wdata <= wdata_i;
            end
        end
    end

    // Word array write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (access && acc_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=3 and LATENCY=1 instances,
// directed scenarios plus random traffic against a timeline model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: per instance, the cycle its pending ack is due (-1 = none)
    int          ack_at [2] = '{-1, -1};
    bit          perr   [2];
    bit          pwe    [2];
    int          pidx   [2];
    logic [31:0] pdata  [2];
    logic [31:0] erd    [2];
    bit          rk     [2];
    logic [31:0] mm     [2][256];
    bit          mv     [2][256];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
        .clk_i   (clk),
        .rst_i   (rst[0]),
        .req_i   (req[0]),
        .we_i    (we[0]),
        .addr_i  (addr[0]),
        .wdata_i (wdata[0]),
        .stall_o (stall[0]),
        .ack_o   (ack[0]),
        .rdata_o (rdata[0]),
        .err_o   (err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst[1]),
        .req_i   (req[1]),
        .we_i    (we[1]),
        .addr_i  (addr[1]),
        .wdata_i (wdata[1]),
        .stall_o (stall[1]),
        .ack_o   (ack[1]),
        .rdata_o (rdata[1]),
        .err_o   (err[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One model cycle for instance k, using inputs that the next edge samples
    task automatic model_step(input int k);
        bit es, ea, ee;
        logic [31:0] a;
        es = 1'b0; ea = 1'b0; ee = 1'b0;
        if (!rst[k]) begin
            ack_at[k] = -1;
            erd[k]    = '0;
            rk[k]     = 1'b1;
        end else if (cyc == ack_at[k]) begin
            ea = 1'b1;
            ee = perr[k];
            if (perr[k]) begin
                erd[k] = '0;
                rk[k]  = 1'b1;
            end else if (pwe[k]) begin
                mm[k][pidx[k]] = pdata[k];
                mv[k][pidx[k]] = 1'b1;
            end else begin
                erd[k] = mm[k][pidx[k]];
                rk[k]  = mv[k][pidx[k]];
            end
        end else if (cyc < ack_at[k]) begin
            es = 1'b1;
        end else begin
            es = req[k];
            if (req[k]) begin
                a       = addr[k];
                perr[k] = ((a % 4) != 0) || ((a >> 2) >= 256);
                pwe[k]  = we[k];
                pdata[k] = wdata[k];
                pidx[k] = perr[k] ? 0 : int'(a >> 2);
                ack_at[k] = cyc + (perr[k] ? 1 : lat(k));
            end
        end
        chk($sformatf("stall%0d_c%0d", k, cyc), 32'(stall[k]), 32'(es));
        chk($sformatf("ack%0d_c%0d", k, cyc), 32'(ack[k]), 32'(ea));
        chk($sformatf("err%0d_c%0d", k, cyc), 32'(err[k]), 32'(ee));
        if (rk[k]) begin
            chk($sformatf("rdata%0d_c%0d", k, cyc), rdata[k], erd[k]);
        end
    endtask

    // Compare process: every cycle, both instances, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            model_step(k);
        end
        cyc++;
    end

    // Issue one request; called just after a rising edge
    task automatic access(input int k, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit hold,
                          input logic [31:0] na, output int rel,
                          output logic [31:0] rd, output bit e);
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        rel = -1;
        rd  = '0;
        e   = 1'b0;
        for (int i = 0; i < 20 && rel < 0; i++) begin
            @(negedge clk);
            if (ack[k] === 1'b1) begin
                rel = i;
                rd  = rdata[k];
                e   = err[k];
            end
        end
        if (rel < 0) begin
            chk("ack_timeout", 32'(rel), 32'(0));
        end
        if (hold) begin
            #1;
            addr[k] = na;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            req[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rel;
        logic [31:0] rd;
        bit          e;
        logic [31:0] a;
        int          sel;
        for (int k = 0; k < 2; k++) begin
            rst[k]   = 1'b1;
            req[k]   = 1'b0;
            we[k]    = 1'b0;
            addr[k]  = '0;
            wdata[k] = '0;
        end
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall[0]), 32'(0));
        chk("rst_ack", 32'(ack[0]), 32'(0));
        chk("rst_err", 32'(err[0]), 32'(0));
        chk("rst_rdata", rdata[0], 32'h0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;

        // Store then load, full latency
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, rel, rd, e);
        chk("s1_st_ack_cyc", 32'(rel), 32'(3));
        chk("s1_st_err", 32'(e), 32'(0));
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s1_ld_ack_cyc", 32'(rel), 32'(3));
        chk("s1_ld_data", rd, 32'hDEADBEEF);
        @(negedge clk);
        chk("s1_ld_held", rdata[0], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Misaligned load rejected in one cycle
        access(0, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s2_err_cyc", 32'(rel), 32'(1));
        chk("s2_err", 32'(e), 32'(1));
        chk("s2_rdata", rd, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s2_reload", rd, 32'hDEADBEEF);

        // Range boundary
        access(0, 1'b1, 32'h400, 32'h11111111, 1'b0, 32'h0, rel, rd, e);
        chk("s3_oor_cyc", 32'(rel), 32'(1));
        chk("s3_oor_err", 32'(e), 32'(1));
        access(0, 1'b1, 32'h3FC, 32'h13579BDF, 1'b0, 32'h0, rel, rd, e);
        chk("s3_top_err", 32'(e), 32'(0));
        access(0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s3_top_data", rd, 32'h13579BDF);

        // Back-to-back loads with req held through DONE
        access(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h3FC, rel, rd, e);
        chk("s4_a_cyc", 32'(rel), 32'(3));
        chk("s4_a_data", rd, 32'hDEADBEEF);
        access(0, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s4_b_cyc", 32'(rel), 32'(3));
        chk("s4_b_data", rd, 32'h13579BDF);

        // Reset aborts an in-flight store
        access(0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 32'h0, rel, rd, e);
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = 32'h20;
        wdata[0] = 32'h12345678;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("s5_stall", 32'(stall[0]), 32'(0));
        chk("s5_ack", 32'(ack[0]), 32'(0));
        chk("s5_err", 32'(err[0]), 32'(0));
        chk("s5_rdata", rdata[0], 32'h0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s5_kept", rd, 32'hAAAA5555);

        // Single-cycle instance
        access(1, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, 32'h0, rel, rd, e);
        chk("s6_st_cyc", 32'(rel), 32'(1));
        access(1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, rel, rd, e);
        chk("s6_ld_cyc", 32'(rel), 32'(1));
        chk("s6_ld_data", rd, 32'h0BADF00D);

        // Random traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 60; n++) begin
                sel = int'($urandom_range(0, 9));
                if (sel <= 5) begin
                    a = 32'($urandom_range(0, 15)) * 4;
                end else if (sel == 6) begin
                    a = 32'h3FC;
                end else if (sel == 7) begin
                    a = 32'($urandom_range(0, 15)) * 4
                        + 32'($urandom_range(1, 3));
                end else if (sel == 8) begin
                    a = 32'h400 + 32'($urandom_range(0, 100)) * 4;
                end else begin
                    a = $urandom | 32'h8000_0000;
                end
                access(k, 1'($urandom_range(0, 1)), a, $urandom,
                       1'b0, 32'h0, rel, rd, e);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
